// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register with hold/shift-right/shift-left/load
// modes and a per-frame shift counter that pulses frame_done on every WIDTH-th shift.
module universal_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int             CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q;

    // Unknown mode values match no case item and fall through to hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else begin
            case (mode)
                2'b01:   q <= {ser_in_r, q[WIDTH-1:1]};
                2'b10:   q <= {q[WIDTH-2:0], ser_in_l};
                2'b11:   q <= par_in;
                default: q <= q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (mode)
                2'b01, 2'b10: begin
                    if (shift_cnt == CNT_LAST) begin
                        shift_cnt  <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end
                2'b11:   shift_cnt <= '0;
                default: shift_cnt <= shift_cnt;
            endcase
        end
    end

    assign par_out   = q;
    assign ser_out_r = q[0];
    assign ser_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: stimulus pushes model predictions,
// a monitor pops and compares them after every clock edge or reset assertion.
module tb_universal_shift_reg;

    localparam int W = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          ser_in_r;
    logic          ser_in_l;
    logic [W-1:0]  par_in;
    logic [W-1:0]  par_out;
    logic          ser_out_r;
    logic          ser_out_l;
    logic [CW-1:0] shift_cnt;
    logic          frame_done;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .ser_in_r   (ser_in_r),
        .ser_in_l   (ser_in_l),
        .par_in     (par_in),
        .par_out    (par_out),
        .ser_out_r  (ser_out_r),
        .ser_out_l  (ser_out_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        int           cnt;
        bit           fd;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: register value as a plain integer, shifts counted per frame.
    logic [W-1:0] mq;
    int           mcnt;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input bit fd);
        exp_t e;
        e.q   = mq;
        e.cnt = mcnt;
        e.fd  = fd;
        sb.push_back(e);
    endtask

    task automatic step(input logic [1:0] m, input bit r, input bit l, input logic [W-1:0] p);
        bit fd;
        bit shifted;
        @(negedge clk);
        mode     = m;
        ser_in_r = r;
        ser_in_l = l;
        par_in   = p;
        fd       = 1'b0;
        shifted  = 1'b0;
        if (m === 2'b01) begin
            mq = (mq >> 1) | (W'(r) << (W - 1));
            shifted = 1'b1;
        end else if (m === 2'b10) begin
            mq = (mq << 1) | W'(l);
            shifted = 1'b1;
        end else if (m === 2'b11) begin
            mq   = p;
            mcnt = 0;
        end
        if (shifted) begin
            mcnt = mcnt + 1;
            if (mcnt == W) begin
                mcnt = 0;
                fd   = 1'b1;
            end
        end
        push(fd);
    endtask

    task automatic areset();
        @(negedge clk);
        mode = 2'b00;
        #1;
        mq   = '0;
        mcnt = 0;
        push(1'b0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: after any edge or reset assertion, compare all pending predictions.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("par_out",    int'(par_out),    int'(e.q));
                chk("ser_out_r",  int'(ser_out_r),  int'(e.q[0]));
                chk("ser_out_l",  int'(ser_out_l),  int'(e.q[W-1]));
                chk("shift_cnt",  int'(shift_cnt),  e.cnt);
                chk("frame_done", int'(frame_done), int'(e.fd));
            end
        end
    end

    initial begin
        logic [1:0] lseq [4];
        int wait_cyc;
        rst_n    = 1'b0;
        mode     = 2'b00;
        ser_in_r = 1'b0;
        ser_in_l = 1'b0;
        par_in   = '0;
        mq       = '0;
        mcnt     = 0;
        #12;
        rst_n = 1'b1;

        // Reset checked immediately, then holds
        areset();
        repeat (3) step(2'b00, 1'b1, 1'b1, 8'hFF);

        // Load A5, then 8 right shifts of zeros
        step(2'b11, 1'b0, 1'b0, 8'hA5);
        repeat (8) step(2'b01, 1'b0, 1'b0, 8'h00);

        // Left fill 1,1,0,1 then zeros
        areset();
        lseq = '{2'd1, 2'd1, 2'd0, 2'd1};
        for (int i = 0; i < 4; i++) step(2'b10, 1'b0, lseq[i][0], 8'h00);
        repeat (4) step(2'b10, 1'b0, 1'b0, 8'h00);

        // Holds mid-frame with a direction change
        step(2'b11, 1'b0, 1'b0, 8'h5A);
        repeat (3) step(2'b01, 1'($urandom), 1'b0, 8'h00);
        repeat (5) step(2'b00, 1'b1, 1'b1, 8'h00);
        repeat (5) step(2'b10, 1'b0, 1'($urandom), 8'h00);
        step(2'b00, 1'b0, 1'b0, 8'h00);

        // Load during frame restarts the count
        repeat (5) step(2'b01, 1'($urandom), 1'b0, 8'h00);
        step(2'b11, 1'b0, 1'b0, 8'h3C);
        repeat (8) step(2'b10, 1'b0, 1'($urandom), 8'h00);

        // Load on the edge that would wrap
        step(2'b11, 1'b0, 1'b0, 8'h00);
        repeat (7) step(2'b01, 1'b1, 1'b0, 8'h00);
        step(2'b11, 1'b0, 1'b0, 8'h81);

        // Async reset mid-frame, then continuous streaming
        repeat (6) step(2'b01, 1'($urandom), 1'b0, 8'h00);
        areset();
        repeat (24) step(2'b01, 1'($urandom), 1'b0, 8'h00);

        // Unknown mode behaves as hold
        step(2'b01, 1'b1, 1'b0, 8'h00);
        step(2'bxx, 1'b1, 1'b1, 8'hFF);

        // Random traffic
        repeat (300) step(2'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
        areset();
        repeat (100) step(2'($urandom_range(1, 2)), 1'($urandom), 1'($urandom), 8'h00);

        @(negedge clk);
        mode = 2'b00;
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register: the next-generation successor to the fixed 3-bit SISO right shifter. It adds:
- WIDTH-bit storage.
- Four modes: hold, shift right, shift left, parallel load.
- Parallel output and serial outputs at both ends.
- A shift counter with a frame-complete pulse, so serial-link and SIPO/PISO users can frame WIDTH-bit words without external counters.

Parameters:
WIDTH, 8, storage width in bits; legal range WIDTH >= 2.
RESET_VAL, {WIDTH{1'b0}}, value loaded into the register on reset.
CNT_W, $clog2(WIDTH), width of the shift counter; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
mode  input  2  00 = hold, 01 = shift right, 10 = shift left, 11 = parallel load.
ser_in_r  input  1  serial input entering at the MSB on a right shift.
ser_in_l  input  1  serial input entering at the LSB on a left shift.
par_in  input  WIDTH  parallel load data.
par_out  output  WIDTH  register contents q.
ser_out_r  output  1  q[0], the bit leaving on a right shift.
ser_out_l  output  1  q[WIDTH-1], the bit leaving on a left shift.
shift_cnt  output  CNT_W  shifts completed in the current frame, range 0..WIDTH-1.
frame_done  output  1  one-cycle pulse after the WIDTH-th shift of a frame.

Behaviour:
Clock and reset:
- One clock domain, clk.
- rst_n is asynchronous and active-low. While it is low: q = RESET_VAL, shift_cnt = 0, frame_done = 0, all applied immediately without waiting for a clock edge.
- Operation resumes on the first rising edge after rst_n goes high.
- Reset asserted mid-frame discards the partial frame. No frame_done is generated for it.

Register update on each rising edge:
- hold: q unchanged.
- shift right: q <= {ser_in_r, q[WIDTH-1:1]}.
- shift left: q <= {q[WIDTH-2:0], ser_in_l}.
- load: q <= par_in.
- mode containing X/Z: treated as hold. No state changes.

Outputs and latency:
- All outputs come directly from flops, with no combinational path from inputs.
- ser_out_r and ser_out_l are direct taps of q, so they change only at clock edges or on reset.
- A bit presented on ser_in_r at edge k appears on ser_out_r after edge k+WIDTH-1, provided every edge in between is a right shift. The same rule applies to ser_in_l and ser_out_l.

Counter:
- Either shift direction increments shift_cnt.
- hold leaves shift_cnt unchanged.
- load clears shift_cnt to 0.
- Changing direction mid-frame does not clear the counter; shifts of both directions accumulate.
- Wrap-around: a shift while shift_cnt == WIDTH-1 sets shift_cnt to 0 and sets frame_done to 1 for exactly one cycle.
- On every other edge, frame_done is 0, including hold edges taken while shift_cnt == 0 after a wrap.
- Back-to-back frames: continuous shifting gives one frame_done pulse every WIDTH cycles with no gap.
- Load on the edge that would have wrapped: load wins. shift_cnt = 0 and frame_done = 0.

Test Plan:
1. Reset (WIDTH=8): drive rst_n=0 between clock edges -> par_out=8'h00, shift_cnt=0, frame_done=0 immediately; release, hold 3 cycles -> all outputs unchanged.
2. Load then right shift: mode=11 with par_in=8'hA5, then 8 edges of mode=01 with ser_in_r=0 -> ser_out_r before each shift reads 1,0,1,0,0,1,0,1; final par_out=8'h00; frame_done=1 only in the cycle after the 8th shift; shift_cnt=0.
3. Left shift fill: from reset, mode=10 with ser_in_l sequence 1,1,0,1 -> par_out=8'h0D and shift_cnt=4 after 4 edges; 4 more edges with ser_in_l=0 -> par_out=8'hD0, ser_out_l=1, frame_done pulses once.
4. Hold mid-frame: 3 right shifts, 5 holds, 5 left shifts -> shift_cnt stays 3 during the holds; frame_done pulses once, after the 13th edge (8th shift) only.
5. Load during frame: 5 shifts, then load 8'h3C -> par_out=8'h3C, shift_cnt=0, no frame_done; 7 further shifts give no pulse; the 8th shift gives the pulse.
6. Async reset mid-frame and continuous streaming: 6 shifts, pulse rst_n low for 3 ns between edges -> q=RESET_VAL and shift_cnt=0 at once; then 24 continuous right shifts -> exactly 3 frame_done pulses, at shifts 8, 16 and 24.
